// File: rtl/mips_pkg.sv
// Shared encodings, FSM/ALU enums and helpers for the multi-cycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [2:0] {ADD, SUB, AND, OR, SLT} alu_op_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, R0 hardwired to 0.
module mips_mc_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [32];

  // Register array with async clear; writes to R0 are dropped
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'h0000_0000 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'h0000_0000 : regs_q[raddr2_i];

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS core with a single req/ready memory port shared by fetch and data access.
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  retire,
  output logic                  halted,
  output logic [31:0]           pc_out
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] t_q, t_d, alu_q, alu_d, mdr_q, mdr_d;

  logic [5:0]  op, funct;
  logic [15:0] imm;
  logic [31:0] rf_rd1, rf_rd2, opnd_b, alu_res;
  logic        legal;
  alu_op_t     alu_op;

  assign op    = ir_q[31:26];
  assign funct = ir_q[5:0];
  assign imm   = ir_q[15:0];

  mips_mc_regfile u_rf (
    .clk_i    (clock),
    .rst_i    (reset),
    .we_i     (state_q == WB),
    .waddr_i  ((op == OP_RTYPE) ? ir_q[15:11] : ir_q[20:16]),
    .wdata_i  ((op == OP_LW) ? mdr_q : alu_q),
    .raddr1_i (ir_q[25:21]),
    .raddr2_i (ir_q[20:16]),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2)
  );

  // Instruction legality and ALU operation select
  always_comb begin
    legal  = 1'b0;
    alu_op = ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin legal = 1'b1; alu_op = ADD; end
          FN_SUB:  begin legal = 1'b1; alu_op = SUB; end
          FN_AND:  begin legal = 1'b1; alu_op = AND; end
          FN_OR:   begin legal = 1'b1; alu_op = OR;  end
          FN_SLT:  begin legal = 1'b1; alu_op = SLT; end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // ALU: R-type uses B, immediate forms use the sign-extended offset
  always_comb begin
    opnd_b = (op == OP_RTYPE) ? b_q : sext16(imm);
    case (alu_op)
      ADD:     alu_res = a_q + opnd_b;
      SUB:     alu_res = a_q - opnd_b;
      AND:     alu_res = a_q & opnd_b;
      OR:      alu_res = a_q | opnd_b;
      SLT:     alu_res = {31'd0, ($signed(a_q) < $signed(opnd_b))};
      default: alu_res = a_q + opnd_b;
    endcase
  end

  // Next-state and datapath-register update logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    t_d     = t_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d     = rf_rd1;
        b_d     = rf_rd2;
        t_d     = pc_q + (sext16(imm) << 2);
        state_d = legal ? EXEC : HALT;
      end
      EXEC: begin
        case (op)
          OP_RTYPE, OP_ADDI: begin
            alu_d   = alu_res;
            state_d = WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = alu_res;
            state_d = (alu_res[1:0] != 2'b00) ? HALT : MEM;
          end
          OP_BEQ: begin
            if (a_q == b_q) begin
              pc_d = t_q;
            end
            state_d = FETCH;
          end
          OP_J: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            state_d = FETCH;
          end
          default: state_d = HALT;
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          if (op == OP_LW) begin
            mdr_d   = mem_rdata;
            state_d = WB;
          end else begin
            state_d = FETCH;
          end
        end
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0000_0000;
      a_q     <= 32'h0000_0000;
      b_q     <= 32'h0000_0000;
      t_q     <= 32'h0000_0000;
      alu_q   <= 32'h0000_0000;
      mdr_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
    end
  end

  // Request is gated by reset so it drops the moment reset rises, even though state reads FETCH
  assign mem_req   = ~reset & ((state_q == FETCH) | (state_q == MEM));
  assign mem_we    = (state_q == MEM) & (op == OP_SW);
  assign mem_addr  = (state_q == MEM) ? alu_q[ADDR_WIDTH-1:0] : pc_q[ADDR_WIDTH-1:0];
  assign mem_wdata = b_q;
  assign retire    = (state_q == WB)
                   | ((state_q == EXEC) & ((op == OP_BEQ) | (op == OP_J)))
                   | ((state_q == MEM) & (op == OP_SW) & mem_ready);
  assign halted    = (state_q == HALT);
  assign pc_out    = pc_q;

endmodule
